// File: rtl/mem_interface_pkg.sv
// Shared load/store types for the memory interface: funct3 size codes, FSM states
// and the access-decoding helpers used when a request is accepted.
package mem_interface_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } memif_state_t;

    // Unsigned sizes exist only for loads; re and we together are never legal.
    function automatic logic access_legal(
        input logic       i_re,
        input logic       i_we,
        input logic [2:0] i_funct3,
        input logic [1:0] i_off
    );
        logic w_ok;
        w_ok = 1'b0;
        case (i_funct3)
            MEM_B:   w_ok = 1'b1;
            MEM_H:   w_ok = ~i_off[0];
            MEM_W:   w_ok = (i_off == 2'b00);
            MEM_BU:  w_ok = i_re;
            MEM_HU:  w_ok = i_re & ~i_off[0];
            default: w_ok = 1'b0;
        endcase
        return w_ok & (i_re ^ i_we);
    endfunction

    function automatic logic [3:0] store_strobe(
        input logic [2:0] i_funct3,
        input logic [1:0] i_off
    );
        logic [3:0] w_strb;
        case (i_funct3[1:0])
            2'b00:   w_strb = 4'b0001 << i_off;
            2'b01:   w_strb = 4'b0011 << i_off;
            default: w_strb = 4'b1111;
        endcase
        return w_strb;
    endfunction

    function automatic logic [31:0] store_data(
        input logic [2:0]  i_funct3,
        input logic [31:0] i_wdata
    );
        logic [31:0] w_data;
        case (i_funct3[1:0])
            2'b00:   w_data = {4{i_wdata[7:0]}};
            2'b01:   w_data = {2{i_wdata[15:0]}};
            default: w_data = i_wdata;
        endcase
        return w_data;
    endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Request/grant data-memory port between the load/store unit (master) and memory (slave).
interface mem_interface_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_interface_load_align.sv
// Combinational load extraction: selects the byte/half lane of a read word and
// sign- or zero-extends it according to funct3.
module load_align
    import mem_interface_pkg::*;
(
    input  logic [31:0] i_mem_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_mem_rdata[7:0];
            2'd1:    w_byte = i_mem_rdata[15:8];
            2'd2:    w_byte = i_mem_rdata[23:16];
            default: w_byte = i_mem_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

        case (i_funct3)
            MEM_B:   o_data = {{24{w_byte[7]}}, w_byte};
            MEM_H:   o_data = {{16{w_half[15]}}, w_half};
            MEM_BU:  o_data = {24'h0, w_byte};
            MEM_HU:  o_data = {16'h0, w_half};
            default: o_data = i_mem_rdata;
        endcase
    end
endmodule

// File: rtl/mem_interface.sv
// Load/store unit: turns one re/we strobe from control into a request/grant memory
// transaction and returns aligned, extended load data with a one-cycle done/err.
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              re,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    mem_interface_if.master   bus
);
    localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    memif_state_t      r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct3;
    logic [1:0]        r_offset;
    logic [31:0]       r_rdata;
    logic              r_done;
    logic              r_err;
    logic              r_busy;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_wstrb;
    logic [31:0]       r_mem_wdata;

    logic [31:0]       w_load;
    logic              w_legal;
    logic              w_timeout;

    assign w_legal   = access_legal(re, we, funct3, addr[1:0]);
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    load_align u_load_align (
        .i_mem_rdata (bus.mem_rdata),
        .i_offset    (r_offset),
        .i_funct3    (r_funct3),
        .o_data      (w_load)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_funct3    <= '0;
            r_offset    <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (re || we) begin
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_state     <= REQ;
                            r_cnt       <= '0;
                            r_funct3    <= funct3;
                            r_offset    <= addr[1:0];
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= we;
                            r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            r_mem_wstrb <= store_strobe(funct3, addr[1:0]);
                            r_mem_wdata <= we ? store_data(funct3, wdata) : '0;
                        end else begin
                            // Rejected accesses complete immediately and never touch the bus
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        if (r_mem_we) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end else if (w_timeout) begin
                        r_mem_req <= 1'b0;
                        r_state   <= DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    // Progress wins over a timeout landing in the same cycle
                    if (bus.mem_rvalid) begin
                        r_rdata <= w_load;
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rdata         = r_rdata;
    assign done          = r_done;
    assign err           = r_err;
    assign busy          = r_busy;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.mem_wdata = r_mem_wdata;
endmodule
